param_sync_counter: RTL
=======================

Name: param_sync_counter

Overview:
- Parametrised, fully synchronous successor to the fixed 3-bit JK ripple counter.
- All bits change on one clock edge: no ripple skew, no derived clocks.
- Adds enable, up/down, parallel load, modulus, wrap/saturate mode, cascade terminal-count output and a sticky overflow flag.
- Sits between input switches/clock and LED/display outputs; instances chain through tc to build wider counters.

Parameters:
- WIDTH, 3: counter width in bits, minimum 1.
- MODULUS, 8: number of states; count range is 0..MODULUS-1. Legal range 2..2^WIDTH.
- RESET_VALUE, 0: count value after reset. Must be less than MODULUS.
- SATURATE, 0: 0 = wrap at the limits; 1 = hold at the limits.

Ports:
- input_clock1_1, in, 1: single clock. All state updates on the rising edge.
- input_reset_n, in, 1: synchronous reset, active-low.
- en, in, 1: count enable.
- up, in, 1: direction. 1 = increment, 0 = decrement.
- load, in, 1: parallel load strobe.
- load_value, in, WIDTH: value to load.
- ovf_clear, in, 1: clears the sticky overflow flag.
- count, out, WIDTH: registered count value.
- tc, out, 1: combinational terminal count, used for cascading.
- ovf, out, 1: sticky overflow/underflow flag, registered.

Behaviour:
- Reset: on a rising edge with input_reset_n = 0, count <= RESET_VALUE and ovf <= 0. tc follows from the reset count and current en/up.
- Reset mid-count overrides load, en and ovf_clear in the same cycle.
- Update priority per edge (reset is active-high-inactive, i.e. input_reset_n = 1): load, then en, then hold.
- Load, when load = 1:
  - count <= load_value if load_value < MODULUS, else count <= MODULUS-1 (clamped).
  - Load never sets ovf and ignores en/up.
- Count up, when en = 1 and up = 1:
  - count < MODULUS-1: count <= count+1.
  - count = MODULUS-1: wrap to 0 when SATURATE = 0, hold when SATURATE = 1. ovf <= 1 in both cases.
- Count down, when en = 1 and up = 0:
  - count > 0: count <= count-1.
  - count = 0: wrap to MODULUS-1 when SATURATE = 0, hold when SATURATE = 1. ovf <= 1 in both cases.
- Hold: count is unchanged when en = 0 and load = 0.
- tc = en & ((up & count == MODULUS-1) | (~up & count == 0)).
  - Zero latency; asserted in the cycle before the wrap edge.
  - Feed tc into the next stage's en for a synchronous cascade.
- ovf:
  - Set on the edge where a limit event occurs (a wrap or a saturate hold).
  - Cleared by ovf_clear = 1.
  - If set and clear coincide on the same edge, set wins.
- Arithmetic: internal compare and increment use WIDTH+1 bits, so MODULUS = 2^WIDTH needs no overflow handling in the adder.
- Latency: one cycle from en/load to the new count; no pipelining.
- Direction change takes effect on the very next edge; no dead cycle.

Decomposition:
- Shared package counter_pkg holds:
  - direction constants DIR_UP = 1, DIR_DOWN = 0;
  - mode constants MODE_WRAP = 0, MODE_SAT = 1;
  - function clog2 for callers sizing WIDTH from MODULUS.
- One natural sub-module, counter_next_logic:
  - purely combinational;
  - computes next_count, limit_hit and tc from count, en, up, load and load_value;
  - parametrised identically.
- Top level holds only the count and ovf registers and the reset/priority mux.
- Elaboration check: reject MODULUS > 2^WIDTH and RESET_VALUE >= MODULUS.

Test Plan:
- Default parameters, reset low for 2 edges, then en = 1, up = 1 for 10 edges:
  - count is 0 at reset;
  - count sequence 1..7, 0, 1, 2;
  - tc high only while count = 7;
  - ovf becomes 1 on the 0 wrap.
- WIDTH = 3, MODULUS = 6, en = 1, up = 0 from reset:
  - count sequence 5, 4, 3, 2, 1, 0, 5;
  - tc high only while count = 0.
- WIDTH = 3, MODULUS = 6, SATURATE = 1, load = 1 with load_value = 4, then up for 4 edges:
  - count sequence 4, 5, 5, 5;
  - ovf = 1 after the first hold;
  - ovf_clear = 1 while still counting up keeps ovf = 1 (set wins).
- Load clamp and priority, MODULUS = 6:
  - load_value = 7 with load = 1, en = 1 gives count = 5.
  - Next edge en = 0, up = 1 gives count held at 5 and tc = 0.
- Reset mid-operation: count = 3, ovf = 1, load = 1, input_reset_n = 0 on the same edge gives count = RESET_VALUE (0) and ovf = 0.
- Cascade of two WIDTH = 4, MODULUS = 10 instances (second stage en = first stage tc), 25 enabled edges:
  - stage counts read 2 (tens) and 5 (units);
  - second stage increments only on edges where the first stage goes from 9 to 0.

Source files
------------

// File: rtl/counter_pkg.sv
`timescale 1ns/1ps
// Shared constants and sizing helper for the synchronous counter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_pkg;

  // Direction encoding on the up input
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Behaviour at the count limits, selected by the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold the values 0..value-1. Never returns less than 1,
  // so a caller can size WIDTH directly from MODULUS.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((64'(1) << bits) < 64'(value)) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/counter_next_logic.sv
`timescale 1ns/1ps
// Next-state logic for the synchronous counter: load clamp, up/down step, limit detection, tc.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module counter_next_logic
  import counter_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 8,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next_count,
  output logic             limit_hit,
  output logic             tc
);

  // MODULUS may equal 2^WIDTH, so the modulus itself only fits in WIDTH+1 bits.
  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST_W = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VALUE);

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   ld_x;
  logic [WIDTH-1:0] dec_w;
  logic             at_last;
  logic             at_zero;
  logic             ld_in_range;
  logic             sat_mode;

  // Widened increment: count+1 == MODULUS marks the top state without any
  // carry loss even when MODULUS = 2^WIDTH.
  assign cnt_x       = {1'b0, count};
  assign inc_x       = cnt_x + (WIDTH+1)'(1);
  assign dec_w       = count - WIDTH'(1);
  assign ld_x        = {1'b0, load_value};
  assign at_last     = (inc_x == MOD_X);
  assign at_zero     = (count == '0);
  assign ld_in_range = (ld_x < MOD_X);
  assign sat_mode    = (SATURATE == MODE_SAT);

  // Terminal count looks only at the enable and the limit in the current direction,
  // so a downstream stage enabled by tc steps on exactly the wrap edge.
  assign tc = en & (((up == DIR_UP) & at_last) | ((up == DIR_DOWN) & at_zero));

  // Priority: load (clamped, never a limit event), then enabled step, then hold.
  always_comb begin
    next_count = count;
    limit_hit  = 1'b0;
    if (load) begin
      next_count = ld_in_range ? load_value : LAST_W;
    end else if (en && (up == DIR_UP)) begin
      if (at_last) begin
        limit_hit  = 1'b1;
        next_count = sat_mode ? count : '0;
      end else begin
        next_count = inc_x[WIDTH-1:0];
      end
    end else if (en) begin
      if (at_zero) begin
        limit_hit  = 1'b1;
        next_count = sat_mode ? count : LAST_W;
      end else begin
        next_count = dec_w;
      end
    end
  end

  // Reset value only matters to the top level; kept as a parameter so both
  // files share one parameter set.
  logic unused_rst;
  assign unused_rst = ^RST_W;

endmodule

// File: rtl/param_sync_counter.sv
`timescale 1ns/1ps
// Parametrised synchronous up/down counter with load, modulus, wrap/saturate, tc cascade and sticky ovf.
// Latency: one cycle from en/load to count and ovf; tc is combinational.
// Backpressure: none; the counter accepts an update on every rising edge.
module param_sync_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 8,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = MODE_WRAP
) (
  input  logic             input_clock1_1,
  input  logic             input_reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ovf_clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Reject parameter sets that would make the count range meaningless.
  if (WIDTH < 1) begin : g_bad_width
    $error("param_sync_counter: WIDTH must be at least 1");
  end
  if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_modulus
    $error("param_sync_counter: MODULUS must lie in 2..2^WIDTH");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
    $error("param_sync_counter: RESET_VALUE must be below MODULUS");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("param_sync_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] next_count;
  logic             limit_hit;

  counter_next_logic #(
    .WIDTH       (WIDTH),
    .MODULUS     (MODULUS),
    .RESET_VALUE (RESET_VALUE),
    .SATURATE    (SATURATE)
  ) u_next (
    .count      (count),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .next_count (next_count),
    .limit_hit  (limit_hit),
    .tc         (tc)
  );

  // Count register: reset overrides everything, otherwise take the prioritised next value.
  always_ff @(posedge input_clock1_1) begin
    if (!input_reset_n) begin
      count <= RESET_W;
    end else begin
      count <= next_count;
    end
  end

  // Sticky overflow: a limit event on the same edge as a clear keeps the flag set.
  always_ff @(posedge input_clock1_1) begin
    if (!input_reset_n) begin
      ovf <= 1'b0;
    end else if (limit_hit) begin
      ovf <= 1'b1;
    end else if (ovf_clear) begin
      ovf <= 1'b0;
    end
  end

endmodule
